// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel runtime-loadable clock divider with tick strobes
// Optional CLKDIV_SYNC_EN adds a global sync input that phase-aligns all channels.
module clk_div_multi #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 26,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       ld,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
`ifdef CLKDIV_SYNC_EN
  input  logic                    sync,
`endif
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*DIV_W-1:0] div_cur
);

  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] tick_q;

  // Per-channel priority: ld, then sync (if built), then halted, then disabled, then count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_W'(DEFAULT_DIV);
      end
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ld[i]) begin
          div_q[i]  <= div_in[i*DIV_W +: DIV_W];
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b0;
        end
`ifdef CLKDIV_SYNC_EN
        else if (sync) begin
          cnt_q[i]  <= '0;
          clk_q[i]  <= 1'b0;
          tick_q[i] <= 1'b0;
        end
`endif
        else if (div_q[i] == '0) begin
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b0;
        end else if (!en[i]) begin
          tick_q[i] <= 1'b0;
        end else if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b1;
          clk_q[i]  <= ~clk_q[i];
        end else begin
          cnt_q[i]  <= cnt_q[i] + DIV_W'(1);
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_rdbk
    assign div_cur[g*DIV_W +: DIV_W] = div_q[g];
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - table-driven scoreboard bench for clk_div_multi (NUM_CH=2, DIV_W=4, DEFAULT_DIV=3)
module tb_clk_div_multi;

  logic       CLK;
  logic       RST_N;
  logic [1:0] en;
  logic [1:0] ld;
  logic [7:0] div_in;
`ifdef CLKDIV_SYNC_EN
  logic       sync;
`endif
  logic [1:0] clk_out;
  logic [1:0] tick;
  logic [7:0] div_cur;

  clk_div_multi #(.NUM_CH(2), .DIV_W(4), .DEFAULT_DIV(3)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .en      (en),
    .ld      (ld),
    .div_in  (div_in),
`ifdef CLKDIV_SYNC_EN
    .sync    (sync),
`endif
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur)
  );

  typedef struct {
    logic [1:0] en;
    logic [1:0] ld;
    logic [7:0] div;
    logic       sy;
    logic [1:0] e_tick;
    logic [1:0] e_clk;
    logic [7:0] e_dcur;
  } vec_t;

  vec_t        tbl_main [$];
  vec_t        tbl_post [$];
  logic [11:0] exp_q    [$];
  int          total = 0;
  int          bad   = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [1:0] e, input logic [1:0] l, input logic [7:0] d,
                              input logic s, input logic [1:0] t, input logic [1:0] c,
                              input logic [7:0] dc);
    vec_t v;
    v.en = e; v.ld = l; v.div = d; v.sy = s;
    v.e_tick = t; v.e_clk = c; v.e_dcur = dc;
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] want);
    logic [11:0] got;
    got = {tick, clk_out, div_cur};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got tick=%b clk_out=%b div_cur=%h, want tick=%b clk_out=%b div_cur=%h",
               name, got[11:10], got[9:8], got[7:0], want[11:10], want[9:8], want[7:0]);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    logic [11:0] want;
    en     = v.en;
    ld     = v.ld;
    div_in = v.div;
`ifdef CLKDIV_SYNC_EN
    sync   = v.sy;
`endif
    exp_q.push_back({v.e_tick, v.e_clk, v.e_dcur});
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      bad++;
      total++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      want = exp_q.pop_front();
      check(name, want);
    end
  endtask

  initial begin
    // free run, both channels at reset divisor 3
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b00, 8'h33));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b00, 8'h33));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b11, 8'h33));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b11, 8'h33));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b11, 8'h33));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b00, 8'h33));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b00, 8'h33));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b00, 8'h33));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b11, 8'h33));
    // ch1 divisor 1: tick every cycle, clk_out toggles every cycle
    tbl_main.push_back(mk(2'b11, 2'b10, 8'h10, 0, 2'b00, 2'b11, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b01, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b10, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b00, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b10, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b01, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b11, 8'h13));
    // ch0 disabled for 5 cycles at cnt=1
    for (int k = 0; k < 5; k++)
      tbl_main.push_back(mk(2'b10, 2'b00, 8'h00, 0, 2'b10, (k % 2 == 0) ? 2'b01 : 2'b11, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b11, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b00, 8'h13));
    // ld[0] on the terminal-count cycle wins over the tick
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b10, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b00, 8'h13));
    tbl_main.push_back(mk(2'b11, 2'b01, 8'h15, 0, 2'b10, 2'b10, 8'h15));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b00, 8'h15));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b10, 8'h15));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b00, 8'h15));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b10, 8'h15));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b01, 8'h15));
    // ch0 divisor 0 halts it for 20 cycles, then divisor 2
    tbl_main.push_back(mk(2'b11, 2'b01, 8'h10, 0, 2'b10, 2'b11, 8'h10));
    for (int k = 0; k < 20; k++)
      tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, (k % 2 == 0) ? 2'b01 : 2'b11, 8'h10));
    tbl_main.push_back(mk(2'b11, 2'b01, 8'h12, 0, 2'b10, 2'b01, 8'h12));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b11, 8'h12));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b00, 8'h12));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b10, 8'h12));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b01, 8'h12));
    // simultaneous load on both channels: ch1=2, ch0=3
    tbl_main.push_back(mk(2'b11, 2'b11, 8'h23, 0, 2'b00, 2'b01, 8'h23));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b01, 8'h23));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b10, 2'b11, 8'h23));
    tbl_main.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b01, 2'b10, 8'h23));

    // restart from zero after the mid-count reset
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b00, 8'h33));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b00, 8'h33));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b11, 8'h33));
`ifdef CLKDIV_SYNC_EN
    // ch1 divisor 6 at a different phase, then sync realigns both channels
    tbl_post.push_back(mk(2'b11, 2'b10, 8'h60, 0, 2'b00, 2'b11, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b11, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b01, 2'b10, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b10, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 1, 2'b00, 2'b00, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b00, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b00, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b01, 2'b01, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b01, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b00, 2'b01, 8'h63));
    tbl_post.push_back(mk(2'b11, 2'b00, 8'h00, 0, 2'b11, 2'b10, 8'h63));
`endif

    RST_N  = 1'b0;
    en     = 2'b00;
    ld     = 2'b00;
    div_in = 8'h00;
`ifdef CLKDIV_SYNC_EN
    sync   = 1'b0;
`endif
    @(posedge CLK);
    #1;
    check("reset_state", {2'b00, 2'b00, 8'h33});
    en    = 2'b11;
    RST_N = 1'b1;

    for (int i = 0; i < tbl_main.size(); i++)
      apply($sformatf("main_row%0d", i), tbl_main[i]);

    // tick=01 and div_cur=23 here, so an asynchronous reset is observable without an edge
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset", {2'b00, 2'b00, 8'h33});
    @(posedge CLK);
    #1;
    check("reset_held", {2'b00, 2'b00, 8'h33});
    RST_N = 1'b1;

    for (int i = 0; i < tbl_post.size(); i++)
      apply($sformatf("post_row%0d", i), tbl_post[i]);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
